// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vector encodings, controller
// state encoding and the default exception handler address.
package stall_ctrl_pkg;

  // Thermometer-coded hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM
  localparam logic [3:0] STALL_NONE = 4'b0000;
  localparam logic [3:0] STALL_ID   = 4'b0011;
  localparam logic [3:0] STALL_EX   = 4'b0111;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/stall_ctrl_perf_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module perf_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count enabled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | normal flow; load-use holds PC+IF/ID, multi-cycle op starts
// ST_MC_BUSY | multi-cycle EX op in progress, PC..ID/EX held
// ST_FLUSH   | one-cycle flush, redirect to exception vector
//
// The first stall cycle of a multi-cycle op is spent in ST_RUN (stall is
// combinational from mc_start), so mc_cnt is loaded with N-2 and the op
// finishes in ST_MC_BUSY when mc_cnt reaches zero: N stall cycles total.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallreq_id,
  input  logic             mc_start,
  input  logic [5:0]       mc_cycles,
  input  logic             exc_req,
  input  logic             perf_clr,
  output logic [3:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             mc_done,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e      state_q, state_d;
  logic [5:0]  mc_cnt_q, mc_cnt_d;
  logic [3:0]  stall_d;
  logic        mc_done_d;
  logic        flush_q;
  logic [31:0] new_pc_q;

  // Next-state, stall vector and completion pulse; exception overrides all.
  always_comb begin
    state_d   = state_q;
    mc_cnt_d  = mc_cnt_q;
    stall_d   = STALL_NONE;
    mc_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mc_start && (mc_cycles != 6'd0)) begin
          stall_d = STALL_EX;
          if (mc_cycles == 6'd1) begin
            mc_done_d = 1'b1;
          end else begin
            state_d  = ST_MC_BUSY;
            mc_cnt_d = mc_cycles - 6'd2;
          end
        end else begin
          // A zero-length op completes immediately and costs no stall.
          if (mc_start) mc_done_d = 1'b1;
          if (stallreq_id) stall_d = STALL_ID;
        end
      end
      ST_MC_BUSY: begin
        stall_d = STALL_EX;
        if (mc_cnt_q == 6'd0) begin
          mc_done_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          mc_cnt_d = mc_cnt_q - 6'd1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d  = ST_RUN;
        mc_cnt_d = 6'd0;
      end
    endcase
    // An exception aborts any op in flight; its completion is never reported.
    if (exc_req && (state_q != ST_FLUSH)) begin
      state_d   = ST_FLUSH;
      mc_cnt_d  = 6'd0;
      mc_done_d = 1'b0;
    end
  end

  // State, countdown and registered flush/redirect outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      mc_cnt_q <= 6'd0;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      flush_q  <= (state_d == ST_FLUSH);
      new_pc_q <= (state_d == ST_FLUSH) ? EXC_VECTOR : 32'h0;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign stall   = rst_n ? stall_d : STALL_NONE;
  assign mc_done = rst_n & mc_done_d;
  assign flush   = flush_q;
  assign new_pc  = new_pc_q;
  assign busy    = (state_q == ST_MC_BUSY);

  perf_sat_cnt #(
    .W(CNT_W)
  ) u_perf (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(perf_clr),
    .inc_i(stall[0]),
    .cnt_o(stall_cnt)
  );

endmodule
